// File: rtl/master_req_ctrl_if.sv
// CPU command, bus request and completion signals of master_req_ctrl.
// rsp_err exists only when MREQ_TIMEOUT_EN is defined.
interface master_req_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          req;
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          sfor;
    logic [1:0]    req_stat;
    logic          ack;
    logic          resp;
    logic [DW-1:0] rdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
`ifdef MREQ_TIMEOUT_EN
    logic          rsp_err;
`endif

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, ack, resp, rdata,
        output cmd_ready, req, cmd, addr, wdata, sfor, req_stat, rsp_valid, rsp_rdata
`ifdef MREQ_TIMEOUT_EN
        , rsp_err
`endif
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, ack, resp, rdata,
        input  cmd_ready, req, cmd, addr, wdata, sfor, req_stat, rsp_valid, rsp_rdata
`ifdef MREQ_TIMEOUT_EN
        , rsp_err
`endif
    );
endinterface

// File: rtl/master_req_ctrl.sv
// Master-side request controller: command FIFO feeding one outstanding req/ack/resp transaction.
// Optional ack-wait timeout is enabled by defining MREQ_TIMEOUT_EN.
module master_req_ctrl #(
    parameter int DEPTH   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    master_req_ctrl_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 255)
    begin : g_bad_cfg
        $error("master_req_ctrl: DEPTH must be a power of two in 2..16, TIMEOUT in 1..255");
    end

    typedef enum logic [1:0] {
        S_NO_REQ = 2'd0,
        S_WAIT   = 2'd1,
        S_W_ACK  = 2'd2,
        S_W_DATA = 2'd3
    } state_t;

    state_t        r_state, w_nxt;
    logic          r_fifo_wr    [DEPTH];
    logic [AW-1:0] r_fifo_addr  [DEPTH];
    logic [DW-1:0] r_fifo_wdata [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_push, w_pop, w_done, w_to;
    logic          r_req, r_cmd, r_rsp_valid;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_rsp_rdata;

    assign bus.cmd_ready = (r_cnt != CW'(DEPTH));
    assign w_push        = bus.cmd_valid & bus.cmd_ready;

    // Storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wr[r_wptr]    <= bus.cmd_wr;
            r_fifo_addr[r_wptr]  <= bus.cmd_addr;
            r_fifo_wdata[r_wptr] <= bus.cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef MREQ_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   r_to_cnt <= '0;
        else if (r_state != S_W_ACK)                  r_to_cnt <= '0;
        else if (!bus.ack)                            r_to_cnt <= r_to_cnt + 8'd1;
    end
`endif

    always_comb begin
        w_nxt  = r_state;
        w_pop  = 1'b0;
        w_done = 1'b0;
        w_to   = 1'b0;
        case (r_state)
            S_NO_REQ: if (r_cnt != '0) begin
                w_pop = 1'b1;
                w_nxt = S_WAIT;
            end
            S_WAIT:   w_nxt = S_W_ACK;
            S_W_ACK: begin
                if (bus.ack) begin
                    if (r_cmd) begin
                        w_done = 1'b1;
                        w_nxt  = S_NO_REQ;
                    end else begin
                        w_nxt  = S_W_DATA;
                    end
                end
`ifdef MREQ_TIMEOUT_EN
                // Counter holds the number of ack-less cycles already spent, so this is the last one.
                else if (r_to_cnt == 8'(TIMEOUT - 1)) begin
                    w_to  = 1'b1;
                    w_nxt = S_NO_REQ;
                end
`endif
            end
            S_W_DATA: if (bus.resp) begin
                w_done = 1'b1;
                w_nxt  = S_NO_REQ;
            end
            default:  w_nxt = S_NO_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_NO_REQ;
        else        r_state <= w_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req       <= 1'b0;
            r_cmd       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_req       <= (w_nxt == S_W_ACK);
            r_rsp_valid <= w_done | w_to;
            if (w_pop) begin
                r_cmd   <= r_fifo_wr[r_rptr];
                r_addr  <= r_fifo_addr[r_rptr];
                r_wdata <= r_fifo_wdata[r_rptr];
            end
            if (w_done | w_to)
                r_rsp_rdata <= (r_state == S_W_DATA) ? bus.rdata : '0;
        end
    end

`ifdef MREQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rsp_err <= 1'b0;
        else        r_rsp_err <= w_to;
    end
    assign bus.rsp_err = r_rsp_err;
`endif

    assign bus.req       = r_req;
    assign bus.cmd       = r_cmd;
    assign bus.addr      = r_addr;
    assign bus.wdata     = r_wdata;
    assign bus.sfor      = r_addr[AW-1];
    assign bus.req_stat  = r_state;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_master_req_ctrl.sv
// Directed bench for master_req_ctrl: write, read, stray ack/resp, reset abort, FIFO full, timeout.
module tb_master_req_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   rsp_cnt = 0;
    int   n0;
    bit   ok;

    master_req_ctrl_if #(.AW(32), .DW(32)) bus ();

    master_req_ctrl #(.DEPTH(4), .AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Completion pulses, sampled at the edge that ends the pulse cycle.
    always @(posedge clk) if (bus.rsp_valid) rsp_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_stat(input string tag, input logic [1:0] exp);
        for (int i = 0; i < 40 && bus.req_stat !== exp; i++) tick();
        chk(tag, bus.req_stat, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int budget, output bit acc);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        acc = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.cmd_ready) begin
                acc = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic serve_write(input string tag, input logic [31:0] exp_addr);
        wait_stat({tag, "_stat"}, 2'd2);
        chk({tag, "_addr"}, bus.addr, exp_addr);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk({tag, "_rsp"}, bus.rsp_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.ack       = 1'b0;
        bus.resp      = 1'b0;
        bus.rdata     = '0;

        // Reset state
        #1;
        chk("rst_stat",  bus.req_stat,  2'd0);
        chk("rst_req",   bus.req,       1'b0);
        chk("rst_addr",  bus.addr,      32'h0);
        chk("rst_sfor",  bus.sfor,      1'b0);
        chk("rst_rsp",   bus.rsp_valid, 1'b0);
        chk("rst_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_ready", bus.cmd_ready, 1'b1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Write to slave 1, ack in the third W_ACK cycle
        n0 = rsp_cnt;
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1;
        bus.cmd_addr = 32'h8000_0010; bus.cmd_wdata = 32'hA5A5_0001;
        tick(); bus.cmd_valid = 1'b0;
        chk("t1_stat0", bus.req_stat, 2'd0);
        tick();
        chk("t1_stat1", bus.req_stat, 2'd1);
        chk("t1_req_wait", bus.req, 1'b0);
        chk("t1_sfor", bus.sfor, 1'b1);
        chk("t1_addr", bus.addr, 32'h8000_0010);
        chk("t1_wdata", bus.wdata, 32'hA5A5_0001);
        chk("t1_cmd", bus.cmd, 1'b1);
        tick();
        chk("t1_stat2a", bus.req_stat, 2'd2);
        chk("t1_req", bus.req, 1'b1);
        tick();
        chk("t1_stat2b", bus.req_stat, 2'd2);
        tick();
        chk("t1_stat2c", bus.req_stat, 2'd2);
        bus.ack = 1'b1;
        tick(); bus.ack = 1'b0;
        chk("t1_stat_done", bus.req_stat, 2'd0);
        chk("t1_req_drop", bus.req, 1'b0);
        chk("t1_rsp", bus.rsp_valid, 1'b1);
        chk("t1_rdata", bus.rsp_rdata, 32'h0);
        tick();
        chk("t1_rsp_once", bus.rsp_valid, 1'b0);
        chk("t1_rsp_cnt", rsp_cnt - n0, 1);

        // Read from slave 0, ack in first W_ACK cycle, resp two cycles later
        n0 = rsp_cnt;
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0;
        bus.cmd_addr = 32'h0000_0004; bus.cmd_wdata = 32'h0;
        tick(); bus.cmd_valid = 1'b0;
        tick();
        chk("t2_stat1", bus.req_stat, 2'd1);
        chk("t2_sfor", bus.sfor, 1'b0);
        chk("t2_cmd", bus.cmd, 1'b0);
        tick();
        chk("t2_stat2", bus.req_stat, 2'd2);
        bus.ack = 1'b1;
        tick(); bus.ack = 1'b0;
        chk("t2_stat3a", bus.req_stat, 2'd3);
        chk("t2_req_low", bus.req, 1'b0);
        tick();
        chk("t2_stat3b", bus.req_stat, 2'd3);
        bus.resp = 1'b1; bus.rdata = 32'hDEAD_BEEF;
        tick(); bus.resp = 1'b0;
        chk("t2_stat_done", bus.req_stat, 2'd0);
        chk("t2_rsp", bus.rsp_valid, 1'b1);
        chk("t2_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        tick();
        chk("t2_rsp_cnt", rsp_cnt - n0, 1);

        // Stray ack/resp outside their states
        n0 = rsp_cnt;
        bus.ack = 1'b1; bus.resp = 1'b1;
        tick();
        chk("t4_idle_stat", bus.req_stat, 2'd0);
        chk("t4_idle_rsp", bus.rsp_valid, 1'b0);
        bus.ack = 1'b0; bus.resp = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 32'h0000_0100;
        tick(); bus.cmd_valid = 1'b0;
        bus.ack = 1'b1;
        tick();
        chk("t4_wait_stat", bus.req_stat, 2'd1);
        tick();
        chk("t4_wack_stat", bus.req_stat, 2'd2);
        chk("t4_wack_rsp", bus.rsp_valid, 1'b0);
        bus.ack = 1'b0; bus.resp = 1'b1; bus.rdata = 32'h0BAD_0BAD;
        tick();
        chk("t4_resp_in_wack", bus.req_stat, 2'd2);
        chk("t4_resp_in_wack_rsp", bus.rsp_valid, 1'b0);
        bus.ack = 1'b1;
        tick();
        chk("t4_ack_resp_same", bus.req_stat, 2'd3);
        chk("t4_ack_resp_rsp", bus.rsp_valid, 1'b0);
        bus.ack = 1'b0; bus.resp = 1'b0;
        tick();
        chk("t4_wdata_hold", bus.req_stat, 2'd3);
        bus.resp = 1'b1; bus.rdata = 32'h1234_5678;
        tick(); bus.resp = 1'b0;
        chk("t4_done", bus.req_stat, 2'd0);
        chk("t4_rdata", bus.rsp_rdata, 32'h1234_5678);
        tick();
        chk("t4_rsp_cnt", rsp_cnt - n0, 1);

        // Reset while in W_DATA with another command queued
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 32'h8000_0004;
        tick(); bus.cmd_valid = 1'b0;
        wait_stat("t5_wack", 2'd2);
        bus.ack = 1'b1;
        tick(); bus.ack = 1'b0;
        chk("t5_wdata", bus.req_stat, 2'd3);
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 32'h0000_0200;
        tick(); bus.cmd_valid = 1'b0;
        n0 = rsp_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_stat", bus.req_stat, 2'd0);
        chk("t5_req", bus.req, 1'b0);
        chk("t5_cmd", bus.cmd, 1'b0);
        chk("t5_addr", bus.addr, 32'h0);
        chk("t5_sfor", bus.sfor, 1'b0);
        chk("t5_rdata", bus.rsp_rdata, 32'h0);
        chk("t5_ready", bus.cmd_ready, 1'b1);
        bus.resp = 1'b1; bus.rdata = 32'hFFFF_FFFF;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        bus.resp = 1'b0;
        chk("t5_idle_after", bus.req_stat, 2'd0);
        chk("t5_no_rsp", rsp_cnt - n0, 0);

        // FIFO full: issue register plus four FIFO entries, ack held low
        n0 = rsp_cnt;
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 32'h0000_1000 + 32'(i * 4), 32'(i), 2, ok);
            chk("t3_push", ok, 1'b1);
        end
        chk("t3_full", bus.cmd_ready, 1'b0);
        bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h0000_1014; bus.cmd_wdata = 32'd5;
        tick(); tick(); tick(); tick();
        chk("t3_still_full", bus.cmd_ready, 1'b0);
        chk("t3_head_stat", bus.req_stat, 2'd2);
        chk("t3_head_addr", bus.addr, 32'h0000_1000);
        bus.ack = 1'b1;
        tick(); bus.ack = 1'b0;
        chk("t3_first_rsp", bus.rsp_valid, 1'b1);
        push(1'b1, 32'h0000_1014, 32'd5, 5, ok);
        chk("t3_push6", ok, 1'b1);
        for (int i = 1; i < 6; i++)
            serve_write("t3_order", 32'h0000_1000 + 32'(i * 4));
        tick();
        chk("t3_rsp_cnt", rsp_cnt - n0, 6);

`ifdef MREQ_TIMEOUT_EN
        // Ack never arrives: req high for TIMEOUT cycles, then error completion
        push(1'b1, 32'h8000_0040, 32'h1, 2, ok);
        wait_stat("t6_wack", 2'd2);
        n0 = 0;
        while (bus.req && n0 < 20) begin
            n0++;
            tick();
        end
        chk("t6_req_cycles", n0, 8);
        chk("t6_rsp", bus.rsp_valid, 1'b1);
        chk("t6_err", bus.rsp_err, 1'b1);
        chk("t6_rdata", bus.rsp_rdata, 32'h0);
        chk("t6_stat", bus.req_stat, 2'd0);

        // Ack in the last allowed cycle wins
        push(1'b1, 32'h8000_0044, 32'h2, 2, ok);
        wait_stat("t7_wack", 2'd2);
        for (int i = 0; i < 7; i++) tick();
        chk("t7_req_last", bus.req, 1'b1);
        bus.ack = 1'b1;
        tick(); bus.ack = 1'b0;
        chk("t7_rsp", bus.rsp_valid, 1'b1);
        chk("t7_err", bus.rsp_err, 1'b0);
        chk("t7_stat", bus.req_stat, 2'd0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
